// File: rtl/my_rv_pkg.sv
// Shared fetch-side definitions: machine widths, the canonical NOP, reset vector,
// fetch FSM states and the buffered {pc,instr} entry.
package my_rv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/my_fetch_fifo.sv
// Fetch buffer: DEPTH-entry FIFO of {pc,instr}, head visible combinationally, 1-cycle write-to-read.
// Push and pop may coincide at any occupancy including full; flush empties it in one cycle.
module my_fetch_fifo
  import my_rv_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t wdat_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdat_i;
  end

endmodule

// File: rtl/my_ifetch.sv
// Instruction fetch: issues word fetches, buffers in-order responses, presents head to decode (rsp N -> out N+1).
// Requests throttle so inflight+buffered never exceeds BUF_DEPTH; redirects flush and drain stale responses.
module my_ifetch
  import my_rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int              CW         = $clog2(BUF_DEPTH + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~32'h3;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   fifo_cnt;
  logic [CW:0]     occupancy;
  logic            req_fire;
  logic            rsp_any;
  logic            rsp_live;
  logic            fifo_empty;
  logic            fifo_pop;
  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_wdat;

  // Dropped responses stay in inflight_q, so the throttle also covers them.
  assign occupancy      = {1'b0, inflight_q} + {1'b0, fifo_cnt};
  assign imem_req_valid = rst_n && !redirect_valid && (occupancy < (CW + 1)'(BUF_DEPTH));
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_any  = imem_rsp_valid && (inflight_q != '0);
  assign rsp_live = rsp_any && !redirect_valid && (state_q == FETCH_RUN);

  assign fifo_wdat.pc    = rsp_pc_q;
  assign fifo_wdat.instr = imem_rsp_data;

  assign out_valid = !fifo_empty && !redirect_valid;
  assign fifo_pop  = out_valid && out_ready;
  assign out_instr = out_valid ? fifo_head.instr : NOP_INSTR;
  assign out_pc    = out_valid ? fifo_head.pc    : RESET_PC;

  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    state_d    = state_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_any);
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      pc_d       = redirect_pc & ALIGN_MASK;
      rsp_pc_d   = redirect_pc & ALIGN_MASK;
      drop_cnt_d = inflight_d;
      state_d    = (inflight_d != '0) ? FETCH_DRAIN : FETCH_RUN;
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (rsp_live) rsp_pc_d = rsp_pc_q + 32'd4;
      case (state_q)
        FETCH_RUN: state_d = FETCH_RUN;
        FETCH_DRAIN: begin
          if (rsp_any) drop_cnt_d = drop_cnt_q - CW'(1);
          if (drop_cnt_d == '0) state_d = FETCH_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_RUN;
      pc_q       <= RESET_PC & ALIGN_MASK;
      rsp_pc_q   <= RESET_PC & ALIGN_MASK;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  my_fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (rsp_live),
    .wdat_i  (fifo_wdat),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

endmodule
